// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall encodings for the pipeline sequencer.
// Stall bus bit order: [0]PC [1]IF/ID [2]ID/EX [3]EX/MEM [4]MEM/WB [5]WB.
package pipe_ctrl_pkg;

  localparam int unsigned StallW = 6;

  localparam logic [StallW-1:0] StallNone = 6'b000000;
  localparam logic [StallW-1:0] StallPc   = 6'b000001;
  localparam logic [StallW-1:0] StallIf   = 6'b000011;
  localparam logic [StallW-1:0] StallId   = 6'b000111;
  localparam logic [StallW-1:0] StallMem  = 6'b011111;

  typedef enum logic {
    StIdle,
    StPend
  } state_e;

endpackage

// File: rtl/pipe_ctrl_satcnt.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module pipe_ctrl_satcnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !(&count_q)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: per-stage stall/flush generation, PC-redirect handshake
// toward fetch, and stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              mem_stall_req,
  input  logic              ex_branch_taken,
  input  logic [ADDR_W-1:0] ex_branch_target,
  input  logic              redirect_ready,
  output logic [5:0]        stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_target,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              take_branch;
  logic              redirect_done;

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    take_branch   = 1'b0;
    redirect_done = 1'b0;
    case (state_q)
      StIdle: begin
        // A branch under a memory stall is frozen in EX and re-presents later.
        if (ex_branch_taken && !mem_stall_req) begin
          take_branch = 1'b1;
          target_d    = ex_branch_target;
          state_d     = StPend;
        end
      end
      StPend: begin
        // Younger branches are ignored: the oldest redirect wins.
        if (redirect_ready) begin
          redirect_done = 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    stall = StallNone;
    if (rst) begin
      if (mem_stall_req) begin
        stall = StallMem;
      end else if (id_stall_req) begin
        stall = StallId;
      end else if (if_stall_req) begin
        stall = StallIf;
      end else if (state_q == StPend) begin
        stall = StallPc;
      end
    end
  end

  // Bubbles take precedence over ID/IF stalls on the flushed registers.
  assign flush_if_id     = rst && (take_branch || (state_q == StPend));
  assign flush_id_ex     = rst && take_branch;
  assign redirect_valid  = (state_q == StPend);
  assign redirect_target = target_q;

  pipe_ctrl_satcnt #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (|stall),
    .count (stall_cycles)
  );

  pipe_ctrl_satcnt #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (redirect_done),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// compared against a transaction-level model of the redirect/stall rules.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        if_stall_req, id_stall_req, mem_stall_req;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        redirect_ready;

  logic [5:0]  stall, stall4;
  logic        flush_if_id, flush_id_ex, flush_if_id4, flush_id_ex4;
  logic        redirect_valid, redirect_valid4;
  logic [31:0] redirect_target, redirect_target4;
  logic [31:0] stall_cycles, flush_count;
  logic [3:0]  stall_cycles4, flush_count4;

  pipe_ctrl #(
    .ADDR_W (32),
    .CNT_W  (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_stall_req     (if_stall_req),
    .id_stall_req     (id_stall_req),
    .mem_stall_req    (mem_stall_req),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .redirect_ready   (redirect_ready),
    .stall            (stall),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
  );

  pipe_ctrl #(
    .ADDR_W (32),
    .CNT_W  (4)
  ) dut4 (
    .clk              (clk),
    .rst              (rst),
    .if_stall_req     (if_stall_req),
    .id_stall_req     (id_stall_req),
    .mem_stall_req    (mem_stall_req),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .redirect_ready   (redirect_ready),
    .stall            (stall4),
    .flush_if_id      (flush_if_id4),
    .flush_id_ex      (flush_id_ex4),
    .redirect_valid   (redirect_valid4),
    .redirect_target  (redirect_target4),
    .stall_cycles     (stall_cycles4),
    .flush_count      (flush_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Model: a pending redirect (or none), plus plain integer counters.
  bit          m_pend;
  logic [31:0] m_tgt;
  longint      m_sc, m_fc, m_sc4, m_fc4;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_pend = 0;
    m_tgt  = '0;
    m_sc   = 0;
    m_fc   = 0;
    m_sc4  = 0;
    m_fc4  = 0;
  endtask

  // Called at posedge+1: drive, check before the next edge, advance the model.
  task automatic cycle(input bit mem, input bit id, input bit ifs, input bit br,
                       input logic [31:0] tgt, input bit rdy);
    logic [5:0] e_stall;
    bit         take;
    mem_stall_req    = mem;
    id_stall_req     = id;
    if_stall_req     = ifs;
    ex_branch_taken  = br;
    ex_branch_target = tgt;
    redirect_ready   = rdy;
    #2;
    if (mem)         e_stall = 6'b011111;
    else if (id)     e_stall = 6'b000111;
    else if (ifs)    e_stall = 6'b000011;
    else if (m_pend) e_stall = 6'b000001;
    else             e_stall = 6'b000000;
    take = !m_pend && br && !mem;
    chk("stall", 64'(stall), 64'(e_stall));
    chk("stall4", 64'(stall4), 64'(e_stall));
    chk("flush_if_id", 64'(flush_if_id), 64'(take || m_pend));
    chk("flush_id_ex", 64'(flush_id_ex), 64'(take));
    chk("redirect_valid", 64'(redirect_valid), 64'(m_pend));
    chk("redirect_target", 64'(redirect_target), 64'(m_tgt));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_sc));
    chk("flush_count", 64'(flush_count), 64'(m_fc));
    chk("stall_cycles4", 64'(stall_cycles4), 64'(m_sc4));
    chk("flush_count4", 64'(flush_count4), 64'(m_fc4));
    if (e_stall != 0) begin
      m_sc  = sat(m_sc + 1, 64'hFFFF_FFFF);
      m_sc4 = sat(m_sc4 + 1, 15);
    end
    if (take) begin
      m_pend = 1;
      m_tgt  = tgt;
    end else if (m_pend && rdy) begin
      m_pend = 0;
      m_fc   = sat(m_fc + 1, 64'hFFFF_FFFF);
      m_fc4  = sat(m_fc4 + 1, 15);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, 0);
  endtask

  // Assert reset between edges and check the outputs drop without a clock.
  task automatic mid_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("rst_redirect_valid4", 64'(redirect_valid4), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flush_if_id", 64'(flush_if_id), 64'd0);
    chk("rst_flush_id_ex", 64'(flush_id_ex), 64'd0);
    chk("rst_stall_cycles", 64'(stall_cycles), 64'd0);
    chk("rst_flush_count", 64'(flush_count), 64'd0);
    chk("rst_target", 64'(redirect_target), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    model_reset();
    rst              = 1'b0;
    mem_stall_req    = 1'b1;
    id_stall_req     = 1'b1;
    if_stall_req     = 1'b1;
    ex_branch_taken  = 1'b1;
    ex_branch_target = 32'hDEAD_BEEF;
    redirect_ready   = 1'b0;
    #2;
    // Held in reset with every request high: everything quiet.
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_flush_if_id", 64'(flush_if_id), 64'd0);
    chk("reset_flush_id_ex", 64'(flush_id_ex), 64'd0);
    chk("reset_redirect_valid", 64'(redirect_valid), 64'd0);
    chk("reset_target", 64'(redirect_target), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_stall_req   = 1'b0;
    id_stall_req    = 1'b0;
    if_stall_req    = 1'b0;
    ex_branch_taken = 1'b0;
    @(posedge clk);
    #1;

    // Load-use stall for three cycles.
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 32'h0, 0);
    idle(1);
    chk("t1_stall_cycles", 64'(stall_cycles), 64'd3);

    // Branch accepted on the first redirect cycle.
    cycle(0, 0, 0, 1, 32'h0000_1040, 0);
    cycle(0, 0, 0, 0, 32'h0, 1);
    idle(1);
    chk("t2_flush_count", 64'(flush_count), 64'd1);

    // Fetch holds off the redirect for four cycles.
    cycle(0, 0, 0, 1, 32'h0000_1040, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 32'h0, 0);
    cycle(0, 0, 0, 0, 32'h0, 1);
    idle(1);

    // Branch frozen behind a memory stall, taken once the stall clears.
    cycle(1, 0, 0, 1, 32'h0000_2000, 0);
    cycle(1, 0, 0, 1, 32'h0000_2000, 0);
    cycle(0, 0, 0, 1, 32'h0000_2000, 1);
    cycle(0, 0, 0, 0, 32'h0, 1);
    idle(1);

    // Branch alongside a load-use stall; a younger branch during PEND is dropped.
    cycle(0, 1, 0, 1, 32'h0000_3000, 0);
    cycle(0, 0, 0, 1, 32'h0000_4444, 0);
    chk("t5_target_kept", 64'(redirect_target), 64'h0000_3000);
    cycle(0, 0, 0, 0, 32'h0, 1);
    idle(1);

    // Reset asserted while a redirect is pending.
    cycle(0, 0, 0, 1, 32'h0000_5550, 0);
    mid_reset();
    // Twenty stall cycles saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0, 32'h0, 0);
    idle(1);
    chk("t6_stall_cycles4", 64'(stall_cycles4), 64'hF);
    chk("t6_stall_cycles", 64'(stall_cycles), 64'd20);

    // Random traffic, with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) mid_reset();
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
